// File: rtl/rx_matched_decimator.sv
// rx_matched_decimator
//   Matched filter followed by decimation by OS. Samples are shifted into
//   a NUM_COEFF-deep delay line on accepted strobes; once per block of OS
//   accepted samples (at the latched phase) the full-precision dot product
//   with the coefficient set is registered, then quantized to
//   S(NBT_OUT,NBF_OUT) with saturation and presented with a one-cycle strobe.
//
//   Optional build macro: RX_DEC_ROUND_EN
//     defined   -> round half up (add half an output LSB) before saturation
//     undefined -> truncate discarded fraction bits (toward minus infinity)
//
//   Coefficients come from the packed COEFF_INIT vector
//   (coefficient k at bits [k*NBT_COEFF +: NBT_COEFF]), fixed at elaboration.
//
// Ports
//   clk        in   1        system clock, rising edge
//   i_reset    in   1        asynchronous active-high reset
//   i_valid    in   1        input sample strobe
//   i_is_data  in   NBT_IN   signed oversampled input sample
//   i_phase    in   log2(OS) requested sampling phase (taken at block boundary)
//   o_os_data  out  NBT_OUT  signed decimated symbol, held between strobes
//   o_valid    out  1        one-cycle strobe qualifying o_os_data
//
//   OS must be at least 2; NBF_IN+NBF_COEFF must exceed NBF_OUT.

module rx_matched_decimator #(
  parameter int NUM_COEFF  = 17,
  parameter int OS         = 4,
  parameter     FILE_COEFF = "",
  parameter int NBT_IN     = 8,
  parameter int NBF_IN     = 7,
  parameter int NBT_COEFF  = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NBT_OUT    = 8,
  parameter int NBF_OUT    = 7,
  parameter logic [NUM_COEFF*NBT_COEFF-1:0] COEFF_INIT = '0
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic signed [NBT_IN-1:0]  i_is_data,
  input  logic [$clog2(OS)-1:0]     i_phase,
  output logic signed [NBT_OUT-1:0] o_os_data,
  output logic                      o_valid
);

  localparam int PH_W   = $clog2(OS);
  localparam int PROD_W = NBT_IN + NBT_COEFF;
  localparam int ACC_W  = PROD_W + $clog2(NUM_COEFF);
  localparam int SHIFT  = NBF_IN + NBF_COEFF - NBF_OUT;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OS - 1);

  // Output range expressed at the guarded accumulator width.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - NBT_OUT){1'b0}}, {(NBT_OUT - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - NBT_OUT){1'b1}}, {(NBT_OUT - 1){1'b0}}};

  // Coefficient ROM, fixed after elaboration.
  logic signed [NBT_COEFF-1:0] coeff [NUM_COEFF];

  generate
    for (genvar k = 0; k < NUM_COEFF; k++) begin : g_tap
      assign coeff[k] = COEFF_INIT[k*NBT_COEFF +: NBT_COEFF];
    end
  endgenerate

  // Pipeline state
  logic signed [NBT_IN-1:0]  line_q [NUM_COEFF];
  logic signed [NBT_IN-1:0]  line_d [NUM_COEFF];
  logic [PH_W-1:0]           cnt_q, cnt_d;
  logic [PH_W-1:0]           r_phase_q, r_phase_d;
  logic                      fire_q, fire_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      acc_vld_q, acc_vld_d;
  logic signed [NBT_OUT-1:0] out_q, out_d;
  logic                      vld_q, vld_d;

  logic                      accept;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W:0]     acc_ext;
  logic signed [ACC_W:0]     acc_shr;
  logic signed [NBT_OUT-1:0] out_sat;

  assign accept = i_valid;

  // Delay line, phase counter and fire decision
  always_comb begin
    for (int k = 0; k < NUM_COEFF; k++) line_d[k] = line_q[k];
    cnt_d     = cnt_q;
    r_phase_d = r_phase_q;
    fire_d    = 1'b0;
    if (accept) begin
      for (int k = NUM_COEFF - 1; k > 0; k--) line_d[k] = line_q[k-1];
      line_d[0] = i_is_data;
      // Fire is judged on the pre-increment count against the phase in force.
      fire_d = (cnt_q == r_phase_q);
      if (cnt_q == LAST_PH) begin
        cnt_d     = '0;
        r_phase_d = i_phase;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Full-precision dot product over the line as it stands after the firing
  // sample was shifted in.
  always_comb begin
    acc_sum = '0;
    prod    = '0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      prod    = line_q[k] * coeff[k];
      acc_sum = acc_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    acc_d     = fire_q ? acc_sum : acc_q;
    acc_vld_d = fire_q;
  end

  // Quantize: optional half-LSB bias into a guard bit, then arithmetic
  // shift (floor) and clamp to the output range.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
`ifdef RX_DEC_ROUND_EN
    acc_ext = acc_ext + ((ACC_W+1)'(1) <<< (SHIFT - 1));
`endif
    acc_shr = acc_ext >>> SHIFT;
    if (acc_shr > SAT_MAX)      out_sat = SAT_MAX[NBT_OUT-1:0];
    else if (acc_shr < SAT_MIN) out_sat = SAT_MIN[NBT_OUT-1:0];
    else                        out_sat = acc_shr[NBT_OUT-1:0];
  end

  always_comb begin
    out_d = acc_vld_q ? out_sat : out_q;
    vld_d = acc_vld_q;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_COEFF; k++) line_q[k] <= '0;
      cnt_q     <= '0;
      r_phase_q <= '0;
      fire_q    <= 1'b0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      out_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_COEFF; k++) line_q[k] <= line_d[k];
      cnt_q     <= cnt_d;
      r_phase_q <= r_phase_d;
      fire_q    <= fire_d;
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
    end
  end

  assign o_os_data = out_q;
  assign o_valid   = vld_q;

endmodule
